digital_clock_gen2: RTL
=======================

# digital_clock_gen2

Parametrised, loadable time-of-day counter with 12/24-hour display, alarm, and per-second tick. It is the next generation of the user-area clock block: the top-level wrapper drives its `hours`, `minutes` and `seconds` buses, plus their `*_oeb` enables, onto the user IO pads. Time-set and alarm control come from logic-analyzer or Wishbone-side registers upstream.

## Interface
Parameters:
- `CLK_DIV`, default 10_000_000: `clk` cycles per second. Legal range is 2..2^32-1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  1 = counting enabled; 0 = prescaler and time hold.
- `mode_12h`  in  1  display format: 1 = 12 h, 0 = 24 h.
- `set_valid`  in  1  one-cycle load strobe.
- `set_hours`, `set_minutes`, `set_seconds`  in  6 each  load value, always in 24 h format.
- `alarm_en`  in  1  alarm enable.
- `alarm_hours`, `alarm_minutes`  in  6 each  alarm time, 24 h format.
- `hours`, `minutes`, `seconds`  out  6 each  displayed time, binary.
- `pm`  out  1  1 when the internal hour is ≥ 12, in both modes.
- `hours_oeb`, `minutes_oeb`, `seconds_oeb`  out  6 each  pad output enables, active-low.
- `tick`  out  1  one-cycle pulse per second increment.
- `alarm_irq`  out  1  one-cycle alarm pulse.
- `set_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- Internal state:
  - prescaler `presc`, counting 0..CLK_DIV-1, width $clog2(CLK_DIV);
  - `sec` 0..59, `min` 0..59, `hr` 0..23, always held in 24 h format.
- Prescaler:
  - When `run`=1 and `presc`==CLK_DIV-1, `presc` wraps to 0 and a second-increment occurs on that edge.
  - Otherwise, when `run`=1, `presc` increments.
  - When `run`=0, everything holds.
- Second-increment:
  - `sec` 59→0 carries to `min`; `min` 59→0 carries to `hr`; `hr` 23→0.
  - All carries update on the same edge, so 23:59:59 → 00:00:00 in one step.
- Load: on a `set_valid` edge, values are accepted only if `set_seconds`≤59, `set_minutes`≤59 and `set_hours`≤23.
  - Accepted: `hr`/`min`/`sec` load, `presc` clears to 0, no tick.
  - Rejected: all state is unchanged, and `set_err`=1 for one cycle.
  - Load has priority over a coincident second-increment; that increment is discarded.
  - Load works regardless of `run`.
- Display (combinational from the registers):
  - `minutes`=`min`; `seconds`=`sec`; `pm`=(`hr`≥12).
  - 24 h mode: `hours`=`hr`.
  - 12 h mode: `hr`=0 → 12; 1..12 → `hr`; 13..23 → `hr`-12.
  - `mode_12h` may change on any cycle and affects only the display.
- Alarm: `alarm_irq` is registered. It is 1 for the single cycle following an edge on which a second-increment makes the time equal `alarm_hours`:`alarm_minutes`:00 while `alarm_en`=1.
  - Reaching the alarm time by load never fires the alarm.
  - Alarm values >23 or >59 never match.
- `tick`: registered, 1 for the cycle following every second-increment edge, i.e. the first cycle in which the new time is visible. It is 0 when the increment was overridden by a load.
- Pad enables:
  - All `*_oeb` are 1 (pads released) while `reset_n`=0.
  - They go to 0 on the first rising `clk` edge after reset release and stay 0.

## Timing
- Reset values, applied asynchronously and immediately on `reset_n` low:
  - `presc`=0; time 00:00:00, so `hours`=0 in 24 h mode or 12 in 12 h mode;
  - `pm`=0; `tick`=`alarm_irq`=`set_err`=0; all `*_oeb`=6'h3F.
- Reset deassertion is synchronised by the integrator.
- Period: with `run` held at 1, `tick` is asserted exactly every CLK_DIV cycles.
  - The first tick after reset release or an accepted load occurs CLK_DIV cycles after that edge.
- Load latency: new time is visible the cycle after the `set_valid` edge. `set_err` is asserted in that same cycle.
- Reset mid-operation: everything clears without waiting for `clk`. Pending tick, alarm and error pulses are dropped.
- `run` deasserted on a wrap cycle: that increment does not occur and `presc` holds at CLK_DIV-1.

## Test plan
- Basic counting, CLK_DIV=4, `run`=1, set 00:00:58: `tick` every 4 cycles; after 2 ticks the time reads 00:01:00.
- Full rollover: set 23:59:59, one tick → 00:00:00 with `pm`=0, and every field changes on the same cycle.
- 12 h display at `hr`=0, 11, 12, 13, 23 → `hours`=12, 11, 12, 1, 11 and `pm`=0, 0, 1, 1, 1. With `mode_12h`=0, `hours` equals `hr`.
- Load checks:
  - `set_valid` with 24:00:00 → time unchanged, one `set_err` pulse.
  - 10:20:30 loaded on the prescaler wrap cycle → time reads 10:20:30, no tick, next tick 4 cycles later, 10:20:31.
- Alarm set to 07:00 with `alarm_en`=1:
  - Load 06:59:58 → exactly one `alarm_irq` pulse, coincident with the 07:00:00 `tick`.
  - Load 07:00:00 directly → no pulse.
  - Repeat the first case with `alarm_en`=0 → no pulse.
- Asynchronous reset at 12:34:56 with `clk` stopped: all outputs show reset values immediately with `*_oeb`=3F. The `oeb` buses go to 0 at the first edge after release.

Source files
------------

// File: rtl/digital_clock_gen2.sv
// Loadable time-of-day counter with 12/24 h display,
// alarm pulse, per-second tick and pad output enables.
module digital_clock_gen2 #(
  parameter int unsigned CLK_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       set_valid,
  input  logic [5:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic [5:0] set_seconds,
  input  logic       alarm_en,
  input  logic [5:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  output logic [5:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       pm,
  output logic [5:0] hours_oeb,
  output logic [5:0] minutes_oeb,
  output logic [5:0] seconds_oeb,
  output logic       tick,
  output logic       alarm_irq,
  output logic       set_err
);

  localparam int unsigned PW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST =
    PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    hr_q, hr_d;
  logic          tick_q, tick_d;
  logic          alarm_q, alarm_d;
  logic          err_q, err_d;
  logic          oeb_q;

  logic       wrap;
  logic       set_ok;
  logic       c_min, c_hr;
  logic [5:0] sec_inc, min_inc, hr_inc;
  logic [5:0] hr12;

  // Carry chain for one second-increment
  always_comb begin
    c_min   = (sec_q == 6'd59);
    c_hr    = c_min && (min_q == 6'd59);
    sec_inc = c_min ? 6'd0 : sec_q + 6'd1;
    min_inc = min_q;
    if (c_min)
      min_inc = (min_q == 6'd59) ? 6'd0
                                 : min_q + 6'd1;
    hr_inc = hr_q;
    if (c_hr)
      hr_inc = (hr_q == 6'd23) ? 6'd0
                               : hr_q + 6'd1;
  end

  always_comb begin
    wrap    = run && (presc_q == LAST);
    set_ok  = (set_hours <= 6'd23) &&
              (set_minutes <= 6'd59) &&
              (set_seconds <= 6'd59);
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    tick_d  = 1'b0;
    alarm_d = 1'b0;
    err_d   = 1'b0;
    if (set_valid) begin
      if (set_ok) begin
        presc_d = '0;
        sec_d   = set_seconds;
        min_d   = set_minutes;
        hr_d    = set_hours;
      end else begin
        err_d = 1'b1;
      end
    end else if (wrap) begin
      presc_d = '0;
      sec_d   = sec_inc;
      min_d   = min_inc;
      hr_d    = hr_inc;
      tick_d  = 1'b1;
      alarm_d = alarm_en &&
                (hr_inc == alarm_hours) &&
                (min_inc == alarm_minutes) &&
                (sec_inc == 6'd0);
    end else if (run) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      tick_q  <= 1'b0;
      alarm_q <= 1'b0;
      err_q   <= 1'b0;
      oeb_q   <= 1'b1;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      tick_q  <= tick_d;
      alarm_q <= alarm_d;
      err_q   <= err_d;
      oeb_q   <= 1'b0;
    end
  end

  always_comb begin
    hr12 = hr_q;
    if (hr_q == 6'd0)
      hr12 = 6'd12;
    else if (hr_q > 6'd12)
      hr12 = hr_q - 6'd12;
  end

  assign hours       = mode_12h ? hr12 : hr_q;
  assign minutes     = min_q;
  assign seconds     = sec_q;
  assign pm          = (hr_q >= 6'd12);
  assign tick        = tick_q;
  assign alarm_irq   = alarm_q;
  assign set_err     = err_q;
  assign hours_oeb   = {6{oeb_q}};
  assign minutes_oeb = {6{oeb_q}};
  assign seconds_oeb = {6{oeb_q}};

endmodule
